// File: rtl/demosaic_line_buffer_if.sv
// demosaic_line_buffer_if: Bayer pixel stream in, five-row column with coordinates out
interface demosaic_line_buffer_if #(parameter int ROW_W = 11);
  logic i_vsync;
  logic i_valid;
  logic [7:0] i_data;
  logic o_valid;
  logic [39:0] o_column;
  logic [ROW_W-1:0] o_col;
  logic [ROW_W-1:0] o_row;
  logic o_win_en;
  modport master (
    output i_vsync, i_valid, i_data,
    input  o_valid, o_column, o_col, o_row, o_win_en
  );
  modport slave (
    input  i_vsync, i_valid, i_data,
    output o_valid, o_column, o_col, o_row, o_win_en
  );
endinterface

// File: rtl/demosaic_line_buffer.sv
// demosaic_line_buffer: four line memories feeding a masked five-tap vertical column per pixel
module demosaic_line_buffer #(
  parameter int COLS = 512,
  parameter int ROW_W = 11
) (
  input logic PCLK,
  input logic RST,
  demosaic_line_buffer_if.slave bus
);
  localparam int AW = COLS > 1 ? $clog2(COLS) : 1;
  localparam logic [ROW_W-1:0] LAST = ROW_W'(COLS - 1);
  // one word per column holds {L4, L3, L2, L1}, so the row shift is a single read-first write
  logic [31:0] r_mem [COLS];
  logic [ROW_W-1:0] r_col, r_row;
  logic w_acc;
  logic [AW-1:0] w_addr;
  logic [31:0] w_rd;
  logic [39:0] w_taps;
  assign w_acc = bus.i_vsync & bus.i_valid;
  assign w_addr = r_col[AW-1:0];
  assign w_rd = r_mem[w_addr];
  assign w_taps = {
    r_row >= ROW_W'(4) ? w_rd[31:24] : 8'h00,
    r_row >= ROW_W'(3) ? w_rd[23:16] : 8'h00,
    r_row >= ROW_W'(2) ? w_rd[15:8]  : 8'h00,
    r_row >= ROW_W'(1) ? w_rd[7:0]   : 8'h00,
    bus.i_data
  };
  always_ff @(posedge PCLK)
    if (w_acc) r_mem[w_addr] <= {w_rd[23:0], bus.i_data};
  always_ff @(posedge PCLK or posedge RST)
    if (RST) begin
      r_col <= '0;
      r_row <= '0;
      bus.o_valid <= 1'b0;
      bus.o_win_en <= 1'b0;
      bus.o_column <= '0;
      bus.o_col <= '0;
      bus.o_row <= '0;
    end else begin
      bus.o_valid <= w_acc;
      bus.o_win_en <= w_acc && r_row >= ROW_W'(4);
      if (!bus.i_vsync) begin
        r_col <= '0;
        r_row <= '0;
      end else if (bus.i_valid) begin
        bus.o_column <= w_taps;
        bus.o_col <= r_col;
        bus.o_row <= r_row;
        r_col <= r_col == LAST ? '0 : r_col + 1'b1;
        if (r_col == LAST && r_row != '1) r_row <= r_row + 1'b1;
      end
    end
endmodule
